// File: rtl/l2_port_arbiter_if.sv
// Bundle of the icache, dcache and L2 upstream port signals around l2_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/L2 side.
interface l2_port_arbiter_if #(
    parameter int unsigned s_line = 256,
    parameter int unsigned s_addr = 32
);
    logic              i_read;
    logic              i_write;
    logic [s_addr-1:0] i_address;
    logic [s_line-1:0] i_wdata;
    logic [s_line-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [s_addr-1:0] d_address;
    logic [s_line-1:0] d_wdata;
    logic [s_line-1:0] d_rdata;
    logic              d_resp;

    logic              l2_read;
    logic              l2_write;
    logic [s_addr-1:0] l2_address;
    logic [s_line-1:0] l2_wdata;
    logic [s_line-1:0] l2_rdata;
    logic              l2_resp;

    modport slave (
        input  i_read, i_write, i_address, i_wdata,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output l2_read, l2_write, l2_address, l2_wdata,
        input  l2_rdata, l2_resp
    );

    modport master (
        output i_read, i_write, i_address, i_wdata,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  l2_read, l2_write, l2_address, l2_wdata,
        output l2_rdata, l2_resp
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Arbitrates the L1 icache/dcache line ports onto the single L2 upstream port.
// Dcache wins ties unless the icache has been passed over starve_limit times in a row.
module l2_port_arbiter #(
    parameter int unsigned s_line       = 256,
    parameter int unsigned s_addr       = 32,
    parameter int unsigned starve_limit = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    l2_port_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(starve_limit);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [s_addr-1:0] addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic i_resp_c;
    logic d_resp_c;

    assign i_req = bus.i_read | bus.i_write;
    assign d_req = bus.d_read | bus.d_write;

    // Next-state, grant, latch and starvation-counter logic
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        i_resp_c = 1'b0;
        d_resp_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req && (!i_req || (cnt_q < STARVE_LIM))) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I: begin
                if (bus.l2_resp) begin
                    i_resp_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.l2_resp) begin
                    d_resp_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_d) begin
            state_d = BUSY_D;
            wr_d    = bus.d_write;
            rd_d    = ~bus.d_write;
            addr_d  = bus.d_address;
            wdata_d = bus.d_wdata;
        end else if (grant_i) begin
            state_d = BUSY_I;
            wr_d    = bus.i_write;
            rd_d    = ~bus.i_write;
            addr_d  = bus.i_address;
            wdata_d = bus.i_wdata;
        end else if (i_resp_c || d_resp_c) begin
            // Drop the command on completion so the following IDLE cycle is quiet
            rd_d = 1'b0;
            wr_d = 1'b0;
        end

        if (grant_i) begin
            cnt_d = '0;
        end else if (grant_d && i_req) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else if ((state_q == IDLE) && !i_req) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.l2_read    = rd_q;
    assign bus.l2_write   = wr_q;
    assign bus.l2_address = addr_q;
    assign bus.l2_wdata   = wdata_q;
    assign bus.i_resp     = i_resp_c;
    assign bus.d_resp     = d_resp_c;
    assign bus.i_rdata    = bus.l2_rdata;
    assign bus.d_rdata    = bus.l2_rdata;
endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Two-requester arbiter and sequencer for the shared L2 upstream port. It sits between the split L1 instruction and data caches (their downstream miss/writeback ports) and the single upstream port of the unified L2 cache core. It grants one line transaction at a time and latches that transaction's command, address and write line for its whole duration. The L2 sees a stable request regardless of requester behaviour, and the requester is released with a one-cycle response pulse. Dcache has priority, and a starvation counter bounds the icache wait.

## Interface
- s_line, 256, line width in bits
- s_addr, 32, address width in bits
- starve_limit, 4, consecutive dcache grants allowed while icache waits (1..15)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_read  in  1  icache line-read request
- i_write  in  1  icache line-write request (tie 0 normally; handled generically)
- i_address  in  s_addr  icache line address
- i_wdata  in  s_line  icache write line
- i_rdata  out  s_line  read line to icache
- i_resp  out  1  icache completion pulse
- d_read  in  1  dcache line-read (miss fill) request
- d_write  in  1  dcache line-write (writeback) request
- d_address  in  s_addr  dcache line address
- d_wdata  in  s_line  dcache write line
- d_rdata  out  s_line  read line to dcache
- d_resp  out  1  dcache completion pulse
- l2_read  out  1  L2 read command
- l2_write  out  1  L2 write command
- l2_address  out  s_addr  L2 address (latched)
- l2_wdata  out  s_line  L2 write line (latched)
- l2_rdata  in  s_line  L2 read line
- l2_resp  in  1  L2 completion

## Operation
- States: IDLE, BUSY_I, BUSY_D. Registers: state, latched op (read/write), latched address, latched wdata, 4-bit starve counter.
- Request pending: i_req = i_read|i_write; d_req = d_read|d_write.
- Grant in IDLE, evaluated from current-cycle inputs:
  - d_req only -> BUSY_D.
  - i_req only -> BUSY_I.
  - Both -> BUSY_I if starve counter ≥ starve_limit, else BUSY_D.
  - Neither -> stay IDLE.
- On grant, latch the requester's address and wdata, and op = write if its write is asserted, else read. Read and write both asserted means write.
- Starve counter:
  - Increments (saturating at 15) on each dcache grant made while i_req is high.
  - Clears on any icache grant, or in any IDLE cycle with i_req low.
- In BUSY_x:
  - l2_read/l2_write are driven from the latched op; l2_address and l2_wdata from the latched registers.
  - Requester inputs are ignored; a dropped request does not abort the transaction.
- Completion: in BUSY_x with l2_resp=1, x_resp=1 combinationally in that cycle, and state goes to IDLE. The other requester's resp stays 0.
- i_rdata and d_rdata both pass l2_rdata through unconditionally; they are valid only with the matching resp.
- l2_resp in IDLE is ignored.

## Timing
- Reset, asynchronous: state=IDLE, counter=0, latches=0, so l2_read=l2_write=0, l2_address=0, l2_wdata=0, i_resp=d_resp=0.
- Reset mid-transaction drops the transaction with no resp. The L2 is reset in the same domain.
- Grant latency: request first visible in IDLE at edge t means l2 command asserted from cycle t+1 (registered; no combinational path from requester inputs to l2 command/address/wdata).
- Response latency: zero cycles, l2_resp to x_resp combinational.
- Back-to-back: after l2_resp in cycle r, cycle r+1 is IDLE with no command. The next command starts at r+2.
  - The just-served requester must drop its request in r+1. A still-asserted request in r+1 is treated as a new request.
- Commands are held constant for the entire BUSY period. L2 may take any number of cycles.
- Minimum transaction: 3 cycles of occupancy (IDLE grant, BUSY with resp, IDLE).

## Test plan
- Reset: assert rst_n=0 mid-BUSY_D -> all outputs 0 immediately, no d_resp. Release rst_n, then i_read with address 0x0000_1000 -> l2_read=1, l2_address=0x0000_1000 one cycle later.
- Single dcache writeback: d_write=1, d_address=0x8000_0040, d_wdata=pattern A. L2 responds after 5 cycles -> l2_write high 5 cycles with stable address/data, d_resp one pulse, i_resp=0.
- Simultaneous: i_read and d_read asserted the same cycle, counter 0 -> dcache served first, then icache granted at r+1 with l2_read at r+2.
- Starvation: i_read held, dcache issues 4 back-to-back reads (starve_limit=4) -> 5th arbitration with both pending grants icache; counter reads 0 after.
- Abort/hold: dcache drops d_read during BUSY_D while its address input changes -> l2_address unchanged, d_resp still pulses on l2_resp.
- Spurious l2_resp in IDLE -> no resp pulse, state stays IDLE; read+write both asserted by dcache -> l2_write issued.
